// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, EX forwarding and flush bubbles from EX/MEM/WB destination tags
//
// Ports:
//   clk                     core clock, all state updates on the rising edge
//   reset                   asynchronous active-low reset, clears all tracked state
//   id_valid                instruction present in ID
//   id_rs1, id_rs2          ID source register indices
//   id_rs1_used/_rs2_used   ID instruction really reads that source
//   id_rd, id_rd_we         ID destination index and its write enable
//   id_is_load              ID instruction is a load
//   ex_flush                taken branch/jump resolved in EX, kill the ID instruction
//   stall                   hold PC and IF/ID this cycle
//   fwd_a, fwd_b            EX operand select: 00 regfile, 01 MEM result, 10 WB result
//   wb_rd, wb_we            register file write index and enable
//   stall_count             saturating count of stall cycles
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       id_rd,
    input  logic             id_rd_we,
    input  logic             id_is_load,
    input  logic             ex_flush,
    output logic             stall,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [4:0]       wb_rd,
    output logic             wb_we,
    output logic [CNT_W-1:0] stall_count
);

    typedef struct packed {
        logic       v;
        logic       we;
        logic       ld;
        logic [4:0] rd;
    } tag_t;

    // EX also keeps its sources so forwarding can be resolved there
    typedef struct packed {
        tag_t       t;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
    } ex_t;

    ex_t              ex_q, ex_d;
    tag_t             mem_q, mem_d;
    tag_t             wb_q, wb_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic mem_wr, wb_wr, ex_ld_wr, take;

    always_comb begin
        // x0 never counts as a producer
        mem_wr   = mem_q.v && mem_q.we && mem_q.rd != 5'd0;
        wb_wr    = wb_q.v && wb_q.we && wb_q.rd != 5'd0;
        ex_ld_wr = ex_q.t.v && ex_q.t.ld && ex_q.t.we && ex_q.t.rd != 5'd0;
        // a flush kills the consumer, so it overrides the load-use stall
        stall = id_valid && !ex_flush && ex_ld_wr &&
                ((id_rs1_used && id_rs1 == ex_q.t.rd) || (id_rs2_used && id_rs2 == ex_q.t.rd));
        // MEM checked first: the youngest producer wins
        fwd_a = (mem_wr && ex_q.u1 && mem_q.rd == ex_q.rs1) ? 2'b01 :
                (wb_wr  && ex_q.u1 && wb_q.rd  == ex_q.rs1) ? 2'b10 : 2'b00;
        fwd_b = (mem_wr && ex_q.u2 && mem_q.rd == ex_q.rs2) ? 2'b01 :
                (wb_wr  && ex_q.u2 && wb_q.rd  == ex_q.rs2) ? 2'b10 : 2'b00;
        wb_rd = wb_q.v ? wb_q.rd : 5'd0;
        wb_we = wb_wr;
        // stall or flush puts an all-zero bubble into EX
        take      = !stall && !ex_flush;
        ex_d      = '0;
        ex_d.t.v  = take && id_valid;
        ex_d.t.we = take && id_rd_we;
        ex_d.t.ld = take && id_is_load;
        ex_d.t.rd = take ? id_rd : 5'd0;
        ex_d.rs1  = take ? id_rs1 : 5'd0;
        ex_d.rs2  = take ? id_rs2 : 5'd0;
        ex_d.u1   = take && id_rs1_used;
        ex_d.u2   = take && id_rs2_used;
        mem_d     = ex_q.t;
        wb_d      = mem_q;
        stall_count_d = (stall && stall_count_q != {CNT_W{1'b1}}) ?
                        stall_count_q + CNT_W'(1) : stall_count_q;
        stall_count = stall_count_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q          <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            stall_count_q <= '0;
        end else begin
            ex_q          <= ex_d;
            mem_q         <= mem_d;
            wb_q          <= wb_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0, id_rd_we = 1'b0, id_is_load = 1'b0;
    logic       ex_flush = 1'b0;
    logic       stall, wb_we;
    logic [1:0] fwd_a, fwd_b;
    logic [4:0] wb_rd;
    logic [3:0] stall_count;

    int passed = 0;
    int total = 0;
    int exp_cnt;

    hazard_ctrl #(.CNT_W(4)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load), .ex_flush(ex_flush),
        .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .wb_rd(wb_rd), .wb_we(wb_we),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // present one ID instruction for a cycle; outputs are checked 1 time unit after the falling edge
    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic we, input logic ld,
                         input logic fl);
        @(negedge clk);
        id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        id_rd = rd; id_rd_we = we; id_is_load = ld; ex_flush = fl;
        #1;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // reset held while valid load/consumer traffic is presented
        for (int i = 0; i < 3; i++) begin
            if (i % 2 == 0) drive(1, 0, 0, 0, 0, 5, 1, 1, 0);
            else            drive(1, 5, 1, 1, 1, 6, 1, 0, 0);
            chk("rst_stall", stall, 0);
            chk("rst_fwd", {fwd_a, fwd_b}, 0);
            chk("rst_wb_we", wb_we, 0);
            chk("rst_cnt", stall_count, 0);
        end
        @(negedge clk);
        reset = 1'b1;
        nop();
        chk("rel_stall", stall, 0);
        chk("rel_fwd", {fwd_a, fwd_b}, 0);
        chk("rel_wb", {wb_we, wb_rd}, 0);
        chk("rel_cnt", stall_count, 0);

        // lw x5 ; add x6, x5, x1
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0);
        chk("lu_lw_stall", stall, 0);
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0);
        chk("lu_stall", stall, 1);
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0);
        chk("lu_stall_once", stall, 0);
        chk("lu_cnt", stall_count, 1);
        nop();
        chk("lu_fwd_a", fwd_a, 2'b10);
        chk("lu_fwd_b", fwd_b, 2'b00);
        chk("lu_wb", {wb_we, wb_rd}, {1'b1, 5'd5});
        nop();
        chk("lu_bubble_wb", wb_we, 0);
        nop();
        chk("lu_add_wb", {wb_we, wb_rd}, {1'b1, 5'd6});

        // addi x7 ; addi x7 ; add x8, x7, x7
        drive(1, 0, 1, 0, 0, 7, 1, 0, 0);
        drive(1, 0, 1, 0, 0, 7, 1, 0, 0);
        drive(1, 7, 1, 7, 1, 8, 1, 0, 0);
        chk("pri_stall", stall, 0);
        nop();
        chk("pri_fwd", {fwd_a, fwd_b}, 4'b0101);
        // addi x7 ; addi x7 ; nop ; add x8, x7, x7
        drive(1, 0, 1, 0, 0, 7, 1, 0, 0);
        drive(1, 0, 1, 0, 0, 7, 1, 0, 0);
        nop();
        drive(1, 7, 1, 7, 1, 8, 1, 0, 0);
        nop();
        chk("gap1_fwd", {fwd_a, fwd_b}, 4'b1010);
        // addi x9 ; nop ; nop ; add x10, x9, x9
        drive(1, 0, 1, 0, 0, 9, 1, 0, 0);
        nop();
        nop();
        drive(1, 9, 1, 9, 1, 10, 1, 0, 0);
        nop();
        chk("gap2_fwd", {fwd_a, fwd_b}, 4'b0000);

        // lw x0 ; add x11, x0, x0
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0);
        drive(1, 0, 1, 0, 1, 11, 1, 0, 0);
        chk("x0_stall", stall, 0);
        nop();
        chk("x0_fwd", {fwd_a, fwd_b}, 0);
        nop();
        chk("x0_wb", {wb_we, wb_rd}, 0);
        // lw x3 ; op with rs2 = 3 but rs2 unused
        drive(1, 0, 0, 0, 0, 3, 1, 1, 0);
        drive(1, 4, 1, 3, 0, 12, 1, 0, 0);
        chk("unused_stall", stall, 0);
        nop();
        chk("unused_fwd", {fwd_a, fwd_b}, 0);

        // lw x5 in EX, flush while ID holds its consumer
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0);
        drive(1, 5, 1, 1, 1, 6, 1, 0, 1);
        chk("fl_stall", stall, 0);
        nop();
        chk("fl_fwd", {fwd_a, fwd_b}, 0);
        chk("fl_cnt", stall_count, 1);
        nop();
        chk("fl_lw_wb", {wb_we, wb_rd}, {1'b1, 5'd5});
        nop();
        chk("fl_killed_wb1", wb_we, 0);
        nop();
        chk("fl_killed_wb2", wb_we, 0);

        // lw x5 reading x5, held: stalls every other cycle, 20 stalls in total
        exp_cnt = 1;
        for (int i = 0; i < 40; i++) begin
            drive(1, 5, 1, 0, 0, 5, 1, 1, 0);
            chk($sformatf("sat_stall%0d", i), stall, (i % 2 == 1) ? 1 : 0);
            chk($sformatf("sat_cnt%0d", i), stall_count, exp_cnt);
            if (i % 2 == 1 && exp_cnt < 15) exp_cnt++;
        end
        nop();
        chk("sat_final", stall_count, 15);

        // reset mid-flight with the load about to write back
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_wb", {wb_we, wb_rd}, 0);
        chk("mid_rst_cnt", stall_count, 0);
        @(negedge clk);
        reset = 1'b1;
        nop();
        chk("post_rst_wb", wb_we, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. It tracks destination-register tags for the instructions in EX, MEM and WB, and replaces the bare 5-bit three-stage rd delay chain with a valid/write-enable/load-qualified one. From that state it drives the load-use stall, the EX operand forwarding selects and branch-flush bubbles. It sits beside the decode stage and supplies the write-back register index to the register file.

## Interface
Parameters:
- `CNT_W`, 16: width of the saturating stall-cycle counter.

Ports:
- `clk`, input, 1: core clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset. Asserting it (0) clears all state immediately.
- `id_valid`, input, 1: an instruction is present in ID.
- `id_rs1`, `id_rs2`, input, 5 each: source register indices in ID.
- `id_rs1_used`, `id_rs2_used`, input, 1 each: the ID instruction actually reads that source.
- `id_rd`, input, 5: destination register index in ID.
- `id_rd_we`, input, 1: the ID instruction writes `id_rd`.
- `id_is_load`, input, 1: the ID instruction is a load.
- `ex_flush`, input, 1: taken branch/jump resolved in EX; kill the instruction in ID.
- `stall`, output, 1: hold PC and the IF/ID register this cycle.
- `fwd_a`, `fwd_b`, output, 2 each: EX operand select. 00 = register file, 01 = MEM result, 10 = WB result.
- `wb_rd`, output, 5: register file write index.
- `wb_we`, output, 1: register file write enable.
- `stall_count`, output, `CNT_W`: saturating count of stall cycles.

## Operation
Three tracking stages are kept: EX, MEM and WB.
- Each stage holds: `v` (valid), `rd`, `we`, `ld`.
- EX additionally holds `rs1`, `rs2`, `u1`, `u2`.
- An entry is "writing" when `v && we && rd != 0`. x0 never counts as a producer.

Load-use stall:
- `stall = id_valid && !ex_flush && EX.v && EX.ld && EX.we && EX.rd != 0 && ((id_rs1_used && id_rs1 == EX.rd) || (id_rs2_used && id_rs2 == EX.rd))`.
- Combinational; the core holds ID externally while `stall` is 1.

Forwarding (combinational, EX stage):
- `fwd_a = 01` if MEM is writing and `MEM.rd == EX.rs1` and `EX.u1`.
- Else `fwd_a = 10` if WB is writing and `WB.rd == EX.rs1` and `EX.u1`.
- Else `fwd_a = 00`.
- `fwd_b` is identical, using `rs2`/`u2`.
- MEM has priority over WB, so the youngest producer wins.

Stage advance, every rising edge (no global enable):
- WB ← MEM.
- MEM ← EX.
- EX ← ID fields with `v = id_valid`, only if `!stall && !ex_flush`.
- Otherwise EX ← bubble: `v = 0`, all other fields 0.

Other rules:
- Flush priority: when `ex_flush = 1`, `stall` is forced to 0 and a bubble is inserted. The EX instruction (the branch itself) still advances normally into MEM.
- `wb_rd = WB.v ? WB.rd : 0`.
- `wb_we = WB.v && WB.we && WB.rd != 0`.
- `stall_count` increments by 1 on each edge where `stall = 1`. It saturates at 2^CNT_W − 1 and does not wrap.

## Timing
- Reset (`reset = 0`, asynchronous): all stage fields and `stall_count` are cleared to 0. Consequently `stall = 0`, `fwd_a = fwd_b = 00`, `wb_rd = 0`, `wb_we = 0` while reset is held and on the first cycle after release.
- Reset asserted mid-operation discards all in-flight tags with no drain.
- A load-use hazard produces exactly one `stall` cycle. On the following edge the load moves to MEM, EX holds a bubble and the condition clears.
- The consumer then reaches EX while the load is in WB, and `fwd = 10`.
- ALU producer-to-consumer, back to back: no stall; `fwd = 01` on the consumer's EX cycle.
- ALU producer with a one-instruction gap: `fwd = 10`.
- Producer to consumer with two intervening instructions: `fwd = 00`. The register file is expected to be write-first.
- Latency from `id_*` to `wb_rd`/`wb_we` is 3 edges, absent stall or flush.
- `stall`, `fwd_*`, `wb_*` are combinational from registered state plus `id_*`/`ex_flush`. There are no combinational paths from `fwd_*` back to inputs.
- Simultaneous `ex_flush` and a load-use condition: no stall, and one bubble.

## Test plan
- Reset: hold `reset = 0` for 3 cycles while driving valid ID traffic. Required: `stall = 0`, `fwd = 00`, `wb_we = 0`, `stall_count = 0` throughout and on the first cycle after release.
- Load-use: `lw x5` then `add x6, x5, x1`. Required: `stall = 1` for exactly 1 cycle. On the add's EX cycle `fwd_a = 10`. `stall_count = 1`. `wb_rd = 5` with `wb_we = 1` 3 edges after the lw leaves ID, unaffected by the bubble.
- Forward priority: `addi x7`, `addi x7`, `add x8, x7, x7` back to back. Required: on the add's EX cycle, `fwd_a = fwd_b = 01` (youngest producer). With one nop inserted before the add: both selects `10`.
- x0 and unused sources: `lw x0` then a consumer of x0, then `lw x3` then an instruction with `rs2 = 3` but `id_rs2_used = 0`. Required: `stall = 0` and `fwd = 00` in both cases; `wb_we = 0` for the x0 write.
- Flush: branch in EX with `ex_flush = 1` while ID holds a load-use consumer of an older load. Required: `stall = 0`. Next cycle EX is a bubble and `fwd = 00`. The killed instruction never produces `wb_we = 1`.
- Saturation: `CNT_W = 4`, force 20 consecutive load-use stalls. Required: `stall_count` stops at 15 and does not wrap.
